multdiv_ctrl: RTL
=================

Name: multdiv_ctrl

Overview:
- Sequencing controller between the execute (X) stage and the multicycle multiply/divide units.
- Accepts a mult/div issue from X, freezes the pipeline, and captures and holds the operands for the whole operation.
- Pulses the unit's start control, waits for its ready flag (with a watchdog), then presents the result and exception as a writeback request that is held until accepted.
- Divide-by-zero is short-circuited without starting the divider.

Parameters:
- TIMEOUT, 48, maximum BUSY cycles to wait for md_resultRDY before forcing completion with an exception.
- CNT_W, 6, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- issue_valid  in  1  X stage holds a mult/div instruction this cycle.
- issue_is_div  in  1  1 = divide, 0 = multiply.
- issue_opA  in  32  operand A (dividend / multiplicand).
- issue_opB  in  32  operand B (divisor / multiplier).
- issue_rd  in  5  destination register.
- md_opA  out  32  latched operand A; stable from START until the return to IDLE.
- md_opB  out  32  latched operand B; same stability rule as md_opA.
- md_ctrl_MULT  out  1  one-cycle start pulse to the multiplier.
- md_ctrl_DIV  out  1  one-cycle start pulse to the divider.
- md_result  in  32  result from the selected unit.
- md_exception  in  1  exception from the selected unit.
- md_resultRDY  in  1  ready flag from the selected unit.
- stall  out  1  freeze F/D/X.
- wb_valid  out  1  writeback request.
- wb_rd  out  5  writeback destination.
- wb_data  out  32  writeback data.
- wb_exception  out  1  writeback carries an exception.
- wb_ready  in  1  writeback accepted this cycle.

Behaviour:
- Reset values: all registers and outputs 0; state = IDLE.
  - Reset asserted mid-operation aborts immediately.
  - No start pulse and no wb_valid are produced after reset deasserts.
- States: IDLE, START, BUSY, DONE; 2-bit encoded state register.
- IDLE:
  - stall = issue_valid (combinational), so the issuing instruction does not advance.
  - On issue_valid, latch opA, opB, rd and is_div.
  - If is_div and opB == 0: go to DONE with wb_data = 0 and wb_exception = 1; no start pulse is issued.
  - Otherwise go to START.
- START:
  - Exactly one of md_ctrl_DIV / md_ctrl_MULT is high for this one cycle, selected by the latched is_div.
  - Watchdog counter is cleared to 0.
  - Next state: BUSY.
- BUSY:
  - Watchdog counter increments each cycle.
  - md_resultRDY is ignored in the first BUSY cycle (stale flag from the previous operation).
  - From the second BUSY cycle on, the first md_resultRDY = 1 captures md_result into wb_data and md_exception into wb_exception, then goes to DONE.
  - If the counter reaches TIMEOUT-1 without RDY: wb_data = 0, wb_exception = 1, go to DONE.
  - RDY and timeout in the same cycle: RDY wins.
- DONE:
  - wb_valid = 1; wb_rd, wb_data and wb_exception are held constant.
  - On wb_ready = 1 (same edge), return to IDLE; wb_valid drops on the next cycle.
  - Without wb_ready, DONE holds indefinitely.
- stall is 1 in START, BUSY and DONE.
  - It deasserts in the cycle after the wb_ready handshake.
  - issue_valid outside IDLE is ignored.
  - A new issue is accepted in the first IDLE cycle; back-to-back operations therefore have a one-cycle IDLE gap.
- Operand hold: md_opA and md_opB change only on an IDLE accept, never during START/BUSY/DONE. The divider reads its operands every cycle for sign correction, so this hold is required.
- md_ctrl_MULT and md_ctrl_DIV are never both high, and never high outside START.
- All outputs are registered except stall.

Test Plan:
- Divide 100 / -7: pulse issue_valid with is_div = 1, rd = 5 -> one md_ctrl_DIV pulse in START.
  - Unit RDY at the 34th cycle after the pulse -> wb_valid with wb_data = 0xFFFFFFF2 (-14), wb_rd = 5, wb_exception = 0.
  - stall is continuous from issue until the cycle after wb_ready.
- Divide 9 / 0 -> no md_ctrl pulse; DONE in the cycle after issue with wb_data = 0 and wb_exception = 1.
- Multiply 0x40000000 * 4 with md_exception = 1 at RDY -> md_ctrl_MULT only; wb_exception = 1 and wb_data = md_result.
- Watchdog: no RDY ever -> DONE exactly TIMEOUT (48) BUSY cycles after START with wb_exception = 1 and wb_data = 0.
  - A stale RDY = 1 in the first BUSY cycle is ignored.
- Backpressure and reset:
  - Hold wb_ready = 0 for 10 cycles in DONE -> outputs stable and stall stays 1.
  - Assert reset mid-BUSY -> all outputs 0 immediately; after release a new issue works normally.
- issue_valid held high during BUSY with different operands -> md_opA and md_opB unchanged; the second op is accepted only after the handshake plus one IDLE cycle.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencing controller between the X stage and the multicycle mult/div units.
// Captures an issued operation, holds its operands, pulses the selected unit,
// waits for ready under a watchdog, then holds a writeback request until it
// is accepted. Divide-by-zero finishes without starting the divider.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT = 48,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    BUSY  = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Counter value seen in the last BUSY cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [4:0]       rd_q, rd_d;
  logic             is_div_q, is_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mult_q, mult_d;
  logic             div_q, div_d;
  logic             wbv_q, wbv_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_exc_q, wb_exc_d;

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    mult_d    = 1'b0;
    div_d     = 1'b0;
    wb_data_d = wb_data_q;
    wb_exc_d  = wb_exc_q;

    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          opa_d    = issue_opA;
          opb_d    = issue_opB;
          rd_d     = issue_rd;
          is_div_d = issue_is_div;
          if (issue_is_div && (issue_opB == 32'd0)) begin
            // Divide-by-zero: report the exception without waking the divider.
            state_d   = DONE;
            wb_data_d = 32'd0;
            wb_exc_d  = 1'b1;
          end else begin
            // Start pulses are registered so they coincide with START.
            state_d = START;
            div_d   = issue_is_div;
            mult_d  = ~issue_is_div;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The ready flag in the first BUSY cycle belongs to the previous op.
        if ((cnt_q != '0) && md_resultRDY) begin
          state_d   = DONE;
          wb_data_d = md_result;
          wb_exc_d  = md_exception;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          wb_data_d = 32'd0;
          wb_exc_d  = 1'b1;
        end
      end
      DONE: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wbv_d = (state_d == DONE);
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: reset is asynchronous, so it sits in the sensitivity list and is
    // tested first; sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
      wbv_q     <= 1'b0;
      wb_data_q <= '0;
      wb_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      mult_q    <= mult_d;
      div_q     <= div_d;
      wbv_q     <= wbv_d;
      wb_data_q <= wb_data_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

  // Stall is the only combinational output: it must hold the issuing
  // instruction in X during the very cycle it is accepted.
  assign stall = ~reset & ((state_q != IDLE) | issue_valid);

  assign md_opA       = opa_q;
  assign md_opB       = opb_q;
  assign md_ctrl_MULT = mult_q;
  assign md_ctrl_DIV  = div_q;
  assign wb_valid     = wbv_q;
  assign wb_rd        = rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exception = wb_exc_q;

endmodule
